// File: rtl/field_cfg_loader.sv
// Field configuration loader: streams a preset configuration from the pattern ROM into
// field memory, one word per cycle, through a 1-entry hold buffer for write back-pressure.

package defs;
  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    CFG_1  = 2'd1,
    CFG_2  = 2'd2
  } load_cfg_req_t;
endpackage

module field_cfg_loader
  import defs::*;
#(
  parameter  int FIELD_W = 64,
  parameter  int FIELD_H = 48,
  parameter  int WORD_W  = 16,
  localparam int N_WORDS = FIELD_W * FIELD_H / WORD_W,
  localparam int PTR_W   = $clog2(N_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_go,
  input  load_cfg_req_t       i_cfg_req,
  output logic                o_is_loading,
  output logic                o_done,
  output logic                o_rom_re,
  output logic [PTR_W:0]      o_rom_addr,
  input  logic [WORD_W-1:0]   i_rom_data,
  output logic                o_fld_we,
  output logic [PTR_W-1:0]    o_fld_addr,
  output logic [WORD_W-1:0]   o_fld_data,
  input  logic                i_fld_ready
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_WORDS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_cfg_sel;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic               r_rd_done;
  logic               r_rdv;
  logic               r_hold_v;
  logic [WORD_W-1:0]  r_hold_data;
  logic               r_done;

  logic               w_start;
  logic               w_fld_valid;
  logic               w_accept;
  logic               w_last_accept;
  logic               w_rd_issue;

  assign w_start       = (r_state == S_IDLE) && i_go && (i_cfg_req != NO_REQ);
  assign w_fld_valid   = (r_state == S_LOAD) && (r_hold_v || r_rdv);
  assign w_accept      = w_fld_valid && i_fld_ready;
  assign w_last_accept = w_accept && (r_wr_ptr == LAST);
  // A read is issued only if the slot its word lands in next cycle is free by then.
  assign w_rd_issue    = (r_state == S_LOAD) && !r_rd_done && (!w_fld_valid || i_fld_ready);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves w_state_nxt unassigned (latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)       w_state_nxt = S_LOAD;
      S_LOAD:  if (w_last_accept) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_sel <= 1'b0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_rd_done <= 1'b0;
      r_rdv     <= 1'b0;
      r_hold_v  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last_accept;
      r_rdv  <= w_rd_issue;
      if (w_start) begin
        r_cfg_sel <= (i_cfg_req == CFG_2);
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
        r_rd_done <= 1'b0;
      end
      if (w_rd_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (r_rd_ptr == LAST) r_rd_done <= 1'b1;
      end
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_fld_valid && !i_fld_ready && !r_hold_v) r_hold_v <= 1'b1;
      else if (w_accept)                            r_hold_v <= 1'b0;
    end
  end

  // NOTE: the hold payload is not reset; r_hold_v qualifies it and the output mux masks it.
  always_ff @(posedge clk) begin
    if (w_fld_valid && !i_fld_ready && !r_hold_v) r_hold_data <= i_rom_data;
  end

  assign o_is_loading = (r_state == S_LOAD);
  assign o_done       = r_done;
  assign o_rom_re     = w_rd_issue;
  assign o_rom_addr   = w_rd_issue ? {r_cfg_sel, r_rd_ptr} : '0;
  assign o_fld_we     = w_fld_valid;
  assign o_fld_addr   = w_fld_valid ? r_wr_ptr : '0;
  assign o_fld_data   = !w_fld_valid ? '0 : (r_hold_v ? r_hold_data : i_rom_data);

endmodule

// File: tb/tb_field_cfg_loader.sv
// Directed bench for field_cfg_loader with a 4-word field and a 1-cycle synchronous ROM model.

module tb_field_cfg_loader;
  import defs::*;

  localparam int FIELD_W = 8;
  localparam int FIELD_H = 4;
  localparam int WORD_W  = 8;
  localparam int PTR_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_go = 1'b0;
  load_cfg_req_t     i_cfg_req = NO_REQ;
  logic              o_is_loading, o_done, o_rom_re, o_fld_we;
  logic [PTR_W:0]    o_rom_addr;
  logic [WORD_W-1:0] i_rom_data = '0;
  logic [PTR_W-1:0]  o_fld_addr;
  logic [WORD_W-1:0] o_fld_data;
  logic              i_fld_ready = 1'b1;

  field_cfg_loader #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .i_go(i_go), .i_cfg_req(i_cfg_req),
    .o_is_loading(o_is_loading), .o_done(o_done),
    .o_rom_re(o_rom_re), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_fld_we(o_fld_we), .o_fld_addr(o_fld_addr), .o_fld_data(o_fld_data),
    .i_fld_ready(i_fld_ready)
  );

  always #5 clk = ~clk;

  // ROM model: word = {cfg,addr}*3+1, valid the cycle after the read.
  always @(posedge clk) if (o_rom_re) i_rom_data <= WORD_W'(o_rom_addr) * 8'd3 + 8'd1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Negedge monitor
  int cyc = 0;
  int rd_q[$];
  int wa_q[$];
  int wd_q[$];
  int done_cnt, done_cyc, load_cycles, re_in_stall, bad_we, stab_err;
  logic            prev_stall = 1'b0;
  logic [PTR_W-1:0] prev_addr;
  logic [WORD_W-1:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (o_rom_re) rd_q.push_back(int'(o_rom_addr));
    if (o_fld_we && i_fld_ready) begin
      wa_q.push_back(int'(o_fld_addr));
      wd_q.push_back(int'(o_fld_data));
    end
    if (o_is_loading) load_cycles++;
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_rom_re && o_fld_we && !i_fld_ready) re_in_stall++;
    if (o_fld_we && !o_is_loading) bad_we++;
    if (prev_stall && (!o_fld_we || o_fld_addr != prev_addr || o_fld_data != prev_data)) stab_err++;
    prev_stall = o_fld_we && !i_fld_ready;
    prev_addr  = o_fld_addr;
    prev_data  = o_fld_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    done_cnt = 0; done_cyc = 0; load_cycles = 0; re_in_stall = 0; bad_we = 0; stab_err = 0;
  endtask

  int exp_d1[4] = '{1, 4, 7, 10};
  int exp_d2[4] = '{13, 16, 19, 22};

  task automatic do_load(input load_cfg_req_t cfg, input bit stall, input bit late_go,
                         input string tag);
    int go_cyc, base, extra;
    bit seen;
    clear_mon();
    go_cyc = cyc;
    i_go = 1'b1; i_cfg_req = cfg;
    tick();
    i_go = 1'b0; i_cfg_req = NO_REQ;
    if (late_go) begin
      tick();
      i_go = 1'b1; i_cfg_req = CFG_2;
      tick();
      i_go = 1'b0; i_cfg_req = NO_REQ;
    end
    if (stall) begin
      tick(); tick();
      i_fld_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check({tag, "_stall_we"},   int'(o_fld_we),   1);
        check({tag, "_stall_addr"}, int'(o_fld_addr), 1);
        check({tag, "_stall_data"}, int'(o_fld_data), 4);
        tick();
      end
      i_fld_ready = 1'b1;
    end
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      tick();
      if (done_cnt > 0) seen = 1'b1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    tick(); tick(); tick();
    base  = (cfg == CFG_2) ? 4 : 0;
    extra = stall ? 3 : 0;
    check({tag, "_n_reads"},  rd_q.size(), 4);
    check({tag, "_n_writes"}, wa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_q.size()) check({tag, $sformatf("_rd%0d", i)}, rd_q[i], base + i);
      if (i < wa_q.size()) begin
        check({tag, $sformatf("_wa%0d", i)}, wa_q[i], i);
        check({tag, $sformatf("_wd%0d", i)}, wd_q[i], (cfg == CFG_2) ? exp_d2[i] : exp_d1[i]);
      end
    end
    check({tag, "_done_cnt"},  done_cnt, 1);
    check({tag, "_done_cyc"},  done_cyc - go_cyc, 7 + extra);
    check({tag, "_load_cyc"},  load_cycles, 5 + extra);
    check({tag, "_re_stall"},  re_in_stall, 0);
    check({tag, "_we_idle"},   bad_we, 0);
    check({tag, "_stable"},    stab_err, 0);
  endtask

  initial begin
    clear_mon();
    // 1. reset
    rst = 1'b1;
    tick(); tick();
    check("rst_loading", int'(o_is_loading), 0);
    check("rst_done",    int'(o_done),       0);
    check("rst_rom_re",  int'(o_rom_re),     0);
    check("rst_rom_addr",int'(o_rom_addr),   0);
    check("rst_fld_we",  int'(o_fld_we),     0);
    check("rst_fld_addr",int'(o_fld_addr),   0);
    check("rst_fld_data",int'(o_fld_data),   0);
    rst = 1'b0;
    tick();

    // 2-4. plain loads and a stalled load
    do_load(CFG_1, 1'b0, 1'b0, "cfg1");
    do_load(CFG_2, 1'b0, 1'b0, "cfg2");
    do_load(CFG_1, 1'b1, 1'b0, "stall");

    // 5a. go with NO_REQ is ignored
    clear_mon();
    i_go = 1'b1; i_cfg_req = NO_REQ;
    tick();
    i_go = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    check("noreq_load_cyc", load_cycles, 0);
    check("noreq_reads",    rd_q.size(), 0);
    check("noreq_writes",   wa_q.size(), 0);

    // 5b. CFG_2 go during a CFG_1 load is ignored
    do_load(CFG_1, 1'b0, 1'b1, "lateggo");

    // 6. reset after two accepted writes
    clear_mon();
    i_go = 1'b1; i_cfg_req = CFG_1;
    tick();
    i_go = 1'b0; i_cfg_req = NO_REQ;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("abort_loading", int'(o_is_loading), 0);
    check("abort_fld_we",  int'(o_fld_we),     0);
    check("abort_rom_re",  int'(o_rom_re),     0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("abort_writes",  wa_q.size(), 2);
    check("abort_done",    done_cnt,    0);
    do_load(CFG_2, 1'b0, 1'b0, "reload");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
